addsub_seq: RTL and testbench

Multi-byte add/subtract sequencer that time-shares one 8-bit carry-in adder slice across an operand of NBYTES bytes. It processes one byte per clock, LSB first, and chains carry or borrow between bytes. Subtract uses the invert-and-carry form: O = A − B − CIN. The block sits between a register-file or control FSM and the shared 8-bit add/sub datapath, for wide arithmetic where a full-width adder is too costly.

---
 rtl/addsub_seq.sv | 127 ++++++++++++
 tb/tb_addsub_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// addsub_seq: multi-byte add/subtract sequencer sharing one 8-bit carry slice.
// Optional zero flag output Z is enabled by defining ADDSUB_SEQ_ZERO_FLAG_EN.
module addsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                START,
    input  logic                SUB,
    input  logic                CIN,
    input  logic [8*NBYTES-1:0] A,
    input  logic [8*NBYTES-1:0] B,
    output logic [8*NBYTES-1:0] O,
    output logic                COUT,
    output logic                BUSY,
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    output logic                Z,
`endif
    output logic                DONE
);

    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IW-1:0]        idx;
    logic                 carry;
    logic                 sub_q;
    logic [8*NBYTES-1:0]  a_q;
    logic [8*NBYTES-1:0]  b_q;
    logic [7:0]           a_byte;
    logic [7:0]           b_byte;
    logic [8:0]           sum;
    logic                 accept;
    logic                 last;

    assign accept = START && (state != RUN);
    assign last   = (state == RUN) && (idx == LAST);
    assign BUSY   = (state == RUN);
    assign DONE   = (state == FIN);

    // Current byte slice through the shared adder; subtract inverts B.
    always_comb begin
        a_byte = a_q[{idx, 3'b000} +: 8];
        b_byte = b_q[{idx, 3'b000} +: 8];
        if (sub_q) begin
            b_byte = ~b_byte;
        end
        sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'h00, carry};
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: FIN may restart directly for back-to-back operations.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (START) state_nxt = RUN;
            RUN:  if (last) state_nxt = FIN;
            FIN:  state_nxt = START ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, byte walk, carry chain and result register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            O     <= '0;
            COUT  <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            sub_q <= SUB;
            idx   <= '0;
            carry <= SUB ? ~CIN : CIN;
            O     <= '0;
        end else if (state == RUN) begin
            O[{idx, 3'b000} +: 8] <= sum[7:0];
            carry <= sum[8];
            if (last) begin
                COUT <= sub_q ? ~sum[8] : sum[8];
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    logic zacc;

    // Running AND of per-byte zero tests; published on the last byte.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            zacc <= 1'b0;
            Z    <= 1'b0;
        end else if (accept) begin
            zacc <= 1'b1;
            Z    <= 1'b0;
        end else if (state == RUN) begin
            zacc <= zacc & (sum[7:0] == 8'h00);
            if (last) begin
                Z <= zacc & (sum[7:0] == 8'h00);
            end
        end
    end
`endif

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: randomized self-checking bench for addsub_seq
// against a whole-word arithmetic reference model.
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] o;
    logic        cout;
    logic        busy;
    logic        done;

    logic        start2 = 1'b0;
    logic        sub2 = 1'b0;
    logic        cin2 = 1'b0;
    logic [15:0] a2 = '0;
    logic [15:0] b2 = '0;
    logic [15:0] o2;
    logic        cout2;
    logic        busy2;
    logic        done2;

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    logic        z;
    logic        z2;
`endif

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    addsub_seq #(.NBYTES(4)) dut (
        .CLK(clk), .RESETN(rstn), .START(start), .SUB(sub), .CIN(cin),
        .A(a), .B(b), .O(o), .COUT(cout), .BUSY(busy),
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        .Z(z),
`endif
        .DONE(done)
    );

    addsub_seq #(.NBYTES(2)) dut2 (
        .CLK(clk), .RESETN(rstn), .START(start2), .SUB(sub2), .CIN(cin2),
        .A(a2), .B(b2), .O(o2), .COUT(cout2), .BUSY(busy2),
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        .Z(z2),
`endif
        .DONE(done2)
    );

    // Reference: {cout, o} for a whole-word add or subtract with carry/borrow.
    function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s, input logic c);
        logic [32:0] r;
        if (!s) begin
            r = {1'b0, x} + {1'b0, y} + 33'(c);
        end else begin
            r[31:0] = x - y - 32'(c);
            r[32]   = ({1'b0, x} < ({1'b0, y} + 33'(c)));
        end
        return r;
    endfunction

    // Drive one request on the 4-byte DUT and walk to DONE (bounded).
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic c,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = x; b = y; sub = s; cin = c; start = 1'b1;
        lat = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (busy) bcnt++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o, cout, busy, done} !== 35'h0) begin
            fails++;
            $display("FAIL reset_outputs: got o=%h cout=%b busy=%b done=%b required all 0",
                     o, cout, busy, done);
        end
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        checks++;
        if (z !== 1'b0) begin
            fails++;
            $display("FAIL reset_z: got %b required 0", z);
        end
`endif
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_add;
        int lat, bcnt;
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, lat, bcnt);
        checks++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL add_latency: got %0d required 5", lat);
        end
        checks++;
        if (bcnt !== 4) begin
            fails++;
            $display("FAIL add_busy_cycles: got %0d required 4", bcnt);
        end
        checks++;
        if (o !== 32'h00000100 || cout !== 1'b0) begin
            fails++;
            $display("FAIL add_result: got o=%h cout=%b required 00000100 0", o, cout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || o !== 32'h00000100) begin
            fails++;
            $display("FAIL add_hold: got done=%b busy=%b o=%h required 0 0 00000100",
                     done, busy, o);
        end
    endtask

    task automatic test_sub;
        int lat, bcnt;
        run_op(32'h00000000, 32'h00000001, 1'b1, 1'b0, lat, bcnt);
        checks++;
        if (o !== 32'hFFFFFFFF || cout !== 1'b1 || lat !== 5) begin
            fails++;
            $display("FAIL sub_borrow: got o=%h cout=%b lat=%0d required FFFFFFFF 1 5",
                     o, cout, lat);
        end
        run_op(32'h00000010, 32'h00000005, 1'b1, 1'b1, lat, bcnt);
        checks++;
        if (o !== 32'h0000000A || cout !== 1'b0) begin
            fails++;
            $display("FAIL sub_borrow_in: got o=%h cout=%b required 0000000A 0", o, cout);
        end
    endtask

    task automatic test_carry_chain;
        int lat, bcnt;
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, lat, bcnt);
        checks++;
        if (o !== 32'h00000000 || cout !== 1'b1) begin
            fails++;
            $display("FAIL carry_chain: got o=%h cout=%b required 00000000 1", o, cout);
        end
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        checks++;
        if (z !== 1'b1) begin
            fails++;
            $display("FAIL carry_chain_z: got %b required 1", z);
        end
`endif
    endtask

    task automatic test_random;
        int lat, bcnt;
        logic [31:0] x, y;
        logic s, c;
        logic [32:0] e;
        for (int i = 0; i < 25; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 5 == 0) y = x;
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            e = model(x, y, s, c);
            run_op(x, y, s, c, lat, bcnt);
            checks++;
            if (o !== e[31:0] || cout !== e[32] || lat !== 5) begin
                fails++;
                $display("FAIL random_%0d: a=%h b=%h sub=%b cin=%b got o=%h cout=%b lat=%0d required o=%h cout=%b lat=5",
                         i, x, y, s, c, o, cout, lat, e[31:0], e[32]);
            end
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            checks++;
            if (z !== (e[31:0] == 32'h0)) begin
                fails++;
                $display("FAIL random_z_%0d: got %b required %b", i, z, e[31:0] == 32'h0);
            end
`endif
        end
    endtask

    task automatic test_ignore_start;
        logic [32:0] e;
        logic [31:0] seen;
        int dcnt;
        e = model(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        seen = '0;
        dcnt = 0;
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h0BADF00D; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                seen = o;
            end
        end
        checks++;
        if (dcnt !== 1) begin
            fails++;
            $display("FAIL ignore_start_done_count: got %0d required 1", dcnt);
        end
        checks++;
        if (seen !== e[31:0] || o !== e[31:0] || cout !== e[32]) begin
            fails++;
            $display("FAIL ignore_start_result: got o=%h cout=%b required %h %b",
                     seen, cout, e[31:0], e[32]);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        logic [32:0] e1, e2;
        e1 = model(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0);
        e2 = model(32'h00001000, 32'h00002000, 1'b1, 1'b0);
        run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, lat, bcnt);
        checks++;
        if (o !== e1[31:0] || cout !== e1[32]) begin
            fails++;
            $display("FAIL b2b_first: got o=%h cout=%b required %h %b",
                     o, cout, e1[31:0], e1[32]);
        end
        a = 32'h00001000; b = 32'h00002000; sub = 1'b1; cin = 1'b0; start = 1'b1;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (done) break;
        end
        checks++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL b2b_latency: got %0d required 5", lat);
        end
        checks++;
        if (o !== e2[31:0] || cout !== e2[32]) begin
            fails++;
            $display("FAIL b2b_second: got o=%h cout=%b required %h %b",
                     o, cout, e2[31:0], e2[32]);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bcnt, dcnt;
        logic [32:0] e;
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, lat, bcnt);
        @(negedge clk);
        a = 32'h11223344; b = 32'h01010101; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({o, cout, busy, done} !== 35'h0) begin
            fails++;
            $display("FAIL reset_mid_run: got o=%h cout=%b busy=%b done=%b required all 0",
                     o, cout, busy, done);
        end
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
        checks++;
        if (z !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run_z: got %b required 0", z);
        end
`endif
        rstn = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        checks++;
        if (dcnt !== 0) begin
            fails++;
            $display("FAIL reset_mid_run_no_done: got %0d pulses required 0", dcnt);
        end
        e = model(32'h80000001, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_op(32'h80000001, 32'h7FFFFFFF, 1'b1, 1'b0, lat, bcnt);
        checks++;
        if (o !== e[31:0] || cout !== e[32] || lat !== 5) begin
            fails++;
            $display("FAIL after_reset_op: got o=%h cout=%b lat=%0d required %h %b 5",
                     o, cout, lat, e[31:0], e[32]);
        end
    endtask

    task automatic test_nbytes2;
        int lat;
        logic [15:0] x, y;
        logic s, c;
        logic [16:0] e;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                x = 16'h8000; y = 16'h8000; s = 1'b0; c = 1'b0;
            end else begin
                x = 16'($urandom); y = 16'($urandom);
                s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
            end
            if (!s) begin
                e = {1'b0, x} + {1'b0, y} + 17'(c);
            end else begin
                e[15:0] = x - y - 16'(c);
                e[16] = ({1'b0, x} < ({1'b0, y} + 17'(c)));
            end
            @(negedge clk);
            a2 = x; b2 = y; sub2 = s; cin2 = c; start2 = 1'b1;
            lat = 0;
            while (lat < 40) begin
                @(negedge clk);
                lat++;
                start2 = 1'b0;
                if (done2) break;
            end
            checks++;
            if (o2 !== e[15:0] || cout2 !== e[16] || lat !== 3) begin
                fails++;
                $display("FAIL nbytes2_%0d: a=%h b=%h sub=%b cin=%b got o=%h cout=%b lat=%0d required %h %b 3",
                         i, x, y, s, c, o2, cout2, lat, e[15:0], e[16]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_carry_chain;
        test_random;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid_run;
        test_nbytes2;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
